// File: rtl/teclado_operand_sequencer.sv
// Two-operand decimal entry from keypad events, followed by a registered addition.
// Key presses are edge-detected and registered, so each press is acted on one cycle after it is captured.
//
// state   | meaning
// ENTRY_A | collecting digits for operand A
// ENTRY_B | collecting digits for operand B
// CALC    | single cycle: register the sum and pulse listo
// SHOW    | result on display; a digit key starts a new operation
module teclado_operand_sequencer #(
    parameter int         WIDTH       = 11,
    parameter int         MAX_DIGITS  = 3,
    parameter logic [3:0] KEY_CONFIRM = 4'hA,
    parameter logic [3:0] KEY_BACK    = 4'hB,
    parameter logic [3:0] KEY_CLEAR   = 4'hC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_pressed,
    input  logic [3:0]       key_value,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [WIDTH:0]   sum_out,
    output logic             listo,
    output logic [WIDTH:0]   display_value,
    output logic [1:0]       stage,
    output logic [1:0]       digit_count,
    output logic             overflow_err
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'b00,
        ENTRY_B = 2'b01,
        CALC    = 2'b10,
        SHOW    = 2'b11
    } state_t;

    localparam logic [1:0]       MAX_DC = 2'(MAX_DIGITS);
    localparam logic [WIDTH-1:0] TEN    = WIDTH'(10);

    state_t             state_q, state_d;
    logic               key_pressed_q, key_pressed_d;
    logic               key_ev_q, key_ev_d;
    logic [3:0]         key_val_q, key_val_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [1:0]         dc_q, dc_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH:0]     sum_q, sum_d;
    logic               listo_q, listo_d;
    logic               ovf_q, ovf_d;
    logic               is_digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ENTRY_A;
            key_pressed_q <= 1'b0;
            key_ev_q      <= 1'b0;
            key_val_q     <= 4'd0;
            acc_q         <= '0;
            dc_q          <= 2'd0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            sum_q         <= '0;
            listo_q       <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_pressed_q <= key_pressed_d;
            key_ev_q      <= key_ev_d;
            key_val_q     <= key_val_d;
            acc_q         <= acc_d;
            dc_q          <= dc_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            sum_q         <= sum_d;
            listo_q       <= listo_d;
            ovf_q         <= ovf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        key_pressed_d = key_pressed;
        key_ev_d      = key_pressed & ~key_pressed_q;
        key_val_d     = key_value;
        acc_d         = acc_q;
        dc_d          = dc_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        sum_d         = sum_q;
        listo_d       = 1'b0;
        ovf_d         = ovf_q;
        is_digit      = (key_val_q <= 4'd9);

        case (state_q)
            ENTRY_A, ENTRY_B: begin
                if (key_ev_q) begin
                    if (is_digit) begin
                        if (dc_q < MAX_DC) begin
                            acc_d = acc_q * TEN + WIDTH'(key_val_q);
                            dc_d  = dc_q + 2'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (key_val_q == KEY_BACK) begin
                        if (dc_q != 2'd0) begin
                            acc_d = acc_q / TEN;
                            dc_d  = dc_q - 2'd1;
                        end
                        ovf_d = 1'b0;
                    end else if (key_val_q == KEY_CONFIRM) begin
                        if (dc_q != 2'd0) begin
                            if (state_q == ENTRY_A) begin
                                op_a_d  = acc_q;
                                state_d = ENTRY_B;
                            end else begin
                                op_b_d  = acc_q;
                                state_d = CALC;
                            end
                            acc_d = '0;
                            dc_d  = 2'd0;
                            ovf_d = 1'b0;
                        end
                    end else if (key_val_q == KEY_CLEAR) begin
                        acc_d   = '0;
                        dc_d    = 2'd0;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        sum_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ENTRY_A;
                    end
                end
            end
            CALC: begin
                // Any key event captured during this cycle is intentionally dropped.
                sum_d   = {1'b0, op_a_q} + {1'b0, op_b_q};
                listo_d = 1'b1;
                state_d = SHOW;
            end
            SHOW: begin
                if (key_ev_q) begin
                    if (is_digit) begin
                        acc_d   = WIDTH'(key_val_q);
                        dc_d    = 2'd1;
                        state_d = ENTRY_A;
                    end else if (key_val_q == KEY_CLEAR) begin
                        acc_d   = '0;
                        dc_d    = 2'd0;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        sum_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ENTRY_A;
                    end
                end
            end
            default: state_d = ENTRY_A;
        endcase
    end

    always_comb begin
        case (state_q)
            CALC:    display_value = {1'b0, op_b_q};
            SHOW:    display_value = sum_q;
            default: display_value = {1'b0, acc_q};
        endcase
    end

    assign operand_a    = op_a_q;
    assign operand_b    = op_b_q;
    assign sum_out      = sum_q;
    assign listo        = listo_q;
    assign stage        = state_q;
    assign digit_count  = dc_q;
    assign overflow_err = ovf_q;

endmodule
